// File: rtl/psx_pkg.sv
// Shared constants, state encoding and reply-byte lookup for the PSX digital pad responder.
package psx_pkg;

    localparam logic [7:0] PSX_ADDR_PAD   = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
    localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PSX_PAD_READY  = 8'h5A;

    localparam logic [2:0] PSX_LAST_BYTE  = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StAckWait,
        StAckPulse,
        StIgnore
    } psx_state_e;

    // Byte 0 is sent with the line released, so its value only matters as idle-high bits.
    function automatic logic [7:0] psx_reply_byte(input logic [2:0] idx, input logic [15:0] btn);
        logic [7:0] r;
        case (idx)
            3'd0:    r = 8'hFF;
            3'd1:    r = PSX_ID_DIGITAL;
            3'd2:    r = PSX_PAD_READY;
            3'd3:    r = btn[7:0];
            3'd4:    r = btn[15:8];
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized value.
module psx_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [SYNC_STAGES:0]   prime_q, prime_d;
    logic                   ready;

    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d  = sync_q[SYNC_STAGES-1];
        prime_d = {prime_q[SYNC_STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            prime_q <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            prime_q <= prime_d;
        end
    end

    // Edges are masked until the reset value has flushed out, so a line already low
    // when reset releases is not mistaken for a fresh falling edge.
    assign ready  = prime_q[SYNC_STAGES];
    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = ready & q_o & ~prev_q;
    assign fall_o = ready & ~q_o & prev_q;

endmodule

// File: rtl/psx_pad_responder.sv
// PSX digital pad device side: serial shift, reply generation and timed ACK pulses.
module psx_pad_responder
    import psx_pkg::*;
#(
    parameter int unsigned ACK_DELAY   = 200,
    parameter int unsigned ACK_WIDTH   = 300,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        att_n,
    input  logic        c_clk,
    input  logic        cmd,
    input  logic [15:0] buttons,
    output logic        data_o,
    output logic        data_oe,
    output logic        ack_n,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic [2:0]  byte_index,
    output logic        busy,
    output logic        err
);

    localparam int unsigned CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic att_s, att_rise, att_fall;
    logic c_s, c_rise, c_fall;
    logic cmd_s, cmd_rise, cmd_fall;

    psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_att (
        .clk    (clk),
        .rst    (rst),
        .d_i    (att_n),
        .q_o    (att_s),
        .rise_o (att_rise),
        .fall_o (att_fall)
    );

    psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk    (clk),
        .rst    (rst),
        .d_i    (c_clk),
        .q_o    (c_s),
        .rise_o (c_rise),
        .fall_o (c_fall)
    );

    psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cmd (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cmd),
        .q_o    (cmd_s),
        .rise_o (cmd_rise),
        .fall_o (cmd_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{att_s, cmd_rise, cmd_fall};

    psx_state_e       state_q, state_d;
    logic [15:0]      btn_q, btn_d;
    logic [7:0]       rx_q, rx_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_q, data_d;
    logic             oe_q, oe_d;
    logic             ack_n_q, ack_n_d;
    logic [7:0]       cmd_byte_q, cmd_byte_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [7:0] rx_next;
    logic [2:0] next_idx;
    logic [7:0] reply_cur;
    logic [7:0] reply_next;
    logic       reject;

    assign rx_next    = {cmd_s, rx_q[7:1]};
    assign next_idx   = byte_idx_q + 3'd1;
    assign reply_cur  = psx_reply_byte(byte_idx_q, btn_q);
    assign reply_next = psx_reply_byte(next_idx, btn_q);
    assign reject     = ((byte_idx_q == 3'd0) && (rx_next != PSX_ADDR_PAD)) ||
                        ((byte_idx_q == 3'd1) && (rx_next != PSX_CMD_POLL)) ||
                        (byte_idx_q == PSX_LAST_BYTE);

    always_comb begin
        state_d     = state_q;
        btn_d       = btn_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        oe_d        = oe_q;
        ack_n_d     = ack_n_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;

        if (att_rise) begin
            state_d = StIdle;
            data_d  = 1'b1;
            oe_d    = 1'b0;
            ack_n_d = 1'b1;
            busy_d  = 1'b0;
            // Completing byte 4 always lands in StIgnore, so this covers "fewer than 5 bytes".
            err_d   = busy_q && (state_q != StIgnore);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (att_fall && c_s) begin
                        btn_d      = buttons;
                        rx_d       = '0;
                        bit_cnt_d  = '0;
                        byte_idx_d = '0;
                        busy_d     = 1'b1;
                        state_d    = StShift;
                    end
                end

                StShift: begin
                    if (c_fall) begin
                        data_d = reply_cur[bit_cnt_q];
                        oe_d   = (byte_idx_q != 3'd0);
                    end
                    if (c_rise) begin
                        rx_d      = rx_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            cmd_byte_d  = rx_next;
                            cmd_valid_d = 1'b1;
                            if (reject) begin
                                state_d = StIgnore;
                                data_d  = 1'b1;
                                oe_d    = 1'b0;
                            end else begin
                                state_d = StAckWait;
                                cnt_d   = CNT_W'(1);
                            end
                        end
                    end
                end

                StAckWait, StAckPulse: begin
                    if (c_fall) begin
                        // Host did not wait for ACK: drop it and serve bit 0 of the next byte.
                        ack_n_d    = 1'b1;
                        byte_idx_d = next_idx;
                        data_d     = reply_next[bit_cnt_q];
                        oe_d       = 1'b1;
                        state_d    = StShift;
                    end else if (state_q == StAckWait) begin
                        if (cnt_q == CNT_W'(ACK_DELAY - 1)) begin
                            ack_n_d = 1'b0;
                            cnt_d   = CNT_W'(1);
                            state_d = StAckPulse;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        if (cnt_q == CNT_W'(ACK_WIDTH)) begin
                            ack_n_d    = 1'b1;
                            byte_idx_d = next_idx;
                            state_d    = StShift;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                StIgnore: begin
                    data_d  = 1'b1;
                    oe_d    = 1'b0;
                    ack_n_d = 1'b1;
                end

                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            btn_q       <= 16'hFFFF;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            byte_idx_q  <= '0;
            cnt_q       <= '0;
            data_q      <= 1'b1;
            oe_q        <= 1'b0;
            ack_n_q     <= 1'b1;
            cmd_byte_q  <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            oe_q        <= oe_d;
            ack_n_q     <= ack_n_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Pad-side lines are released combinationally while reset is held.
    assign data_o     = data_q | ~rst;
    assign data_oe    = oe_q & rst;
    assign ack_n      = ack_n_q | ~rst;
    assign cmd_byte   = cmd_byte_q;
    assign cmd_valid  = cmd_valid_q;
    assign byte_index = byte_idx_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule
